// File: rtl/seg_ring_sequencer.sv
// Running-circle animation for an N-digit 7-segment display: a lit head plus an
// optional tail walks the outer segment ring while the digits are time-multiplexed.
module seg_ring_sequencer #(
  parameter int N_DIGITS       = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  localparam int RING_LEN      = 2 * N_DIGITS + 4,
  localparam int POS_W         = $clog2(RING_LEN),
  localparam int DIG_W         = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                step_tick_i,
  input  logic                scan_tick_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                step_i,
  input  logic                dir_i,
  input  logic [1:0]          tail_len_i,
  output logic [6:0]          seg_o,
  output logic [N_DIGITS-1:0] an_o,
  output logic [POS_W-1:0]    pos_o,
  output logic                lap_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam logic [POS_W-1:0]    POS_ZERO = {POS_W{1'b0}};
  localparam logic [POS_W-1:0]    POS_ONE  = POS_W'(1);
  localparam logic [POS_W-1:0]    POS_LAST = POS_W'(RING_LEN - 1);
  localparam logic [DIG_W-1:0]    DIG_ZERO = {DIG_W{1'b0}};
  localparam logic [DIG_W-1:0]    DIG_ONE  = DIG_W'(1);
  localparam logic [DIG_W-1:0]    DIG_LAST = DIG_W'(N_DIGITS - 1);
  localparam logic [6:0]          SEG_OFF  = {7{SEG_ACTIVE_LOW}};
  localparam logic [N_DIGITS-1:0] AN_OFF   = {N_DIGITS{AN_ACTIVE_LOW}};

  state_e              state_q, state_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [DIG_W-1:0]    dig_q, dig_d;
  logic                lap_q, lap_d;
  logic [6:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [POS_W-1:0]    adv_pos_s;
  logic                adv_wrap_s;
  logic [6:0]          lit_s;
  logic [N_DIGITS-1:0] an_act_s;

  // Position k steps behind p; "behind" is opposite to the travel direction.
  function automatic logic [POS_W-1:0] ring_back(input logic [POS_W-1:0] p, input int k,
                                                 input logic ccw);
    int s;
    if (ccw) begin
      s = int'(p) + k;
    end else begin
      s = int'(p) + RING_LEN - k;
    end
    if (s >= RING_LEN) begin
      s = s - RING_LEN;
    end else begin
      s = s;
    end
    return s[POS_W-1:0];
  endfunction

  // Segment mask that ring position p contributes to digit d (zero if on another digit).
  function automatic logic [6:0] seg_at(input logic [POS_W-1:0] p, input logic [DIG_W-1:0] d);
    int pi;
    int di;
    logic [6:0] m;
    pi = int'(p);
    di = int'(d);
    m  = 7'b0000000;
    if (pi < N_DIGITS) begin
      m = (di == pi) ? 7'b0000001 : 7'b0000000;
    end else if (pi == N_DIGITS) begin
      m = (di == N_DIGITS - 1) ? 7'b0000010 : 7'b0000000;
    end else if (pi == N_DIGITS + 1) begin
      m = (di == N_DIGITS - 1) ? 7'b0000100 : 7'b0000000;
    end else if (pi <= 2 * N_DIGITS + 1) begin
      m = (di == 2 * N_DIGITS + 1 - pi) ? 7'b0001000 : 7'b0000000;
    end else if (pi == 2 * N_DIGITS + 2) begin
      m = (di == 0) ? 7'b0010000 : 7'b0000000;
    end else if (pi == 2 * N_DIGITS + 3) begin
      m = (di == 0) ? 7'b0100000 : 7'b0000000;
    end else begin
      m = 7'b0000000;
    end
    return m;
  endfunction

  // One-position advance in the live direction, flagging the ring wrap.
  always_comb begin
    adv_pos_s  = pos_q;
    adv_wrap_s = 1'b0;
    if (dir_i) begin
      adv_wrap_s = (pos_q == POS_ZERO);
      adv_pos_s  = adv_wrap_s ? POS_LAST : (pos_q - POS_ONE);
    end else begin
      adv_wrap_s = (pos_q == POS_LAST);
      adv_pos_s  = adv_wrap_s ? POS_ZERO : (pos_q + POS_ONE);
    end
  end

  // Control FSM next state and head position; stop always has priority over start.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    lap_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (stop_i) begin
          pos_d = POS_ZERO;
        end else if (start_i) begin
          state_d = ST_RUN;
          pos_d   = POS_ZERO;
        end else begin
          pos_d = POS_ZERO;
        end
      end
      ST_RUN: begin
        if (stop_i) begin
          state_d = ST_PAUSE;
        end else if (step_tick_i) begin
          pos_d = adv_pos_s;
          lap_d = adv_wrap_s;
        end else begin
          pos_d = pos_q;
        end
      end
      ST_PAUSE: begin
        if (stop_i) begin
          state_d = ST_IDLE;
          pos_d   = POS_ZERO;
        end else if (start_i) begin
          state_d = ST_RUN;
        end else if (step_i) begin
          pos_d = adv_pos_s;
          lap_d = adv_wrap_s;
        end else begin
          pos_d = pos_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pos_d   = POS_ZERO;
      end
    endcase
  end

  // Digit scan and the lit-segment/anode image for the currently scanned digit.
  always_comb begin
    if (scan_tick_i) begin
      dig_d = (dig_q == DIG_LAST) ? DIG_ZERO : (dig_q + DIG_ONE);
    end else begin
      dig_d = dig_q;
    end
    lit_s    = 7'b0000000;
    an_act_s = {N_DIGITS{1'b0}};
    for (int k = 0; k < 4; k++) begin
      if (k <= int'(tail_len_i)) begin
        lit_s = lit_s | seg_at(ring_back(pos_q, k, dir_i), dig_q);
      end else begin
        lit_s = lit_s;
      end
    end
    for (int i = 0; i < N_DIGITS; i++) begin
      an_act_s[i] = (int'(dig_q) == i);
    end
    if (state_q == ST_IDLE) begin
      lit_s    = 7'b0000000;
      an_act_s = {N_DIGITS{1'b0}};
    end else begin
      lit_s    = lit_s;
      an_act_s = an_act_s;
    end
    seg_d = lit_s ^ SEG_OFF;
    an_d  = an_act_s ^ AN_OFF;
  end

  // State, position, scan index and polarity-corrected display registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      pos_q   <= POS_ZERO;
      dig_q   <= DIG_ZERO;
      lap_q   <= 1'b0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      dig_q   <= dig_d;
      lap_q   <= lap_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg_o  = seg_q;
  assign an_o   = an_q;
  assign pos_o  = pos_q;
  assign lap_o  = lap_q;
  assign busy_o = (state_q == ST_RUN) || (state_q == ST_PAUSE);

endmodule

// File: tb/tb_seg_ring_sequencer.sv
// Bench for seg_ring_sequencer (N_DIGITS=4, active-low): table-driven vectors plus
// corner sequences, checked against a reference model through a scoreboard queue.
module tb_seg_ring_sequencer;
  localparam int N  = 4;
  localparam int RL = 12;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       step_tick, scan_tick, start, stop, step, dir;
  logic [1:0] tail;
  logic [6:0] seg;
  logic [3:0] an;
  logic [3:0] pos;
  logic       lap, busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seg_ring_sequencer #(.N_DIGITS(N), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .step_tick_i(step_tick), .scan_tick_i(scan_tick),
    .start_i(start), .stop_i(stop), .step_i(step), .dir_i(dir), .tail_len_i(tail),
    .seg_o(seg), .an_o(an), .pos_o(pos), .lap_o(lap), .busy_o(busy)
  );

  typedef struct {
    logic [3:0] pos;
    logic       lap;
    logic       busy;
    logic [6:0] seg;
    logic [3:0] an;
  } exp_t;

  typedef struct {
    logic       start, stop, step, tick, dir;
    logic [1:0] tail;
    logic [3:0] e_pos;
    logic       e_lap, e_busy;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  // Ring map for 4 digits, written out position by position.
  int         pos_dig [12] = '{0, 1, 2, 3, 3, 3, 3, 2, 1, 0, 0, 0};
  logic [6:0] pos_seg [12] = '{7'h01, 7'h01, 7'h01, 7'h01, 7'h02, 7'h04,
                               7'h08, 7'h08, 7'h08, 7'h08, 7'h10, 7'h20};

  int         m_state, m_pos, m_dig;
  logic       m_lap;
  logic [6:0] m_seg;
  logic [3:0] m_an;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pos = 0; m_dig = 0; m_lap = 1'b0; m_seg = 7'h7F; m_an = 4'hF;
  endtask

  // Advance the reference model by one clock using the inputs currently driven.
  task automatic model_step();
    int         ns, np, nd, q;
    logic       nl, adv;
    logic [6:0] mask;
    logic [3:0] act;
    exp_t       e;
    mask = 7'h00;
    act  = 4'h0;
    if (m_state != 0) begin
      for (int k = 0; k <= int'(tail); k++) begin
        q = dir ? (m_pos + k) % RL : (m_pos - k + RL) % RL;
        if (pos_dig[q] == m_dig) mask = mask | pos_seg[q];
      end
      act = 4'b0001 << m_dig;
    end
    m_seg = ~mask;
    m_an  = ~act;
    nd  = scan_tick ? (m_dig + 1) % N : m_dig;
    ns  = m_state; np = m_pos; nl = 1'b0; adv = 1'b0;
    case (m_state)
      0: if (!stop && start) begin ns = 1; np = 0; end
      1: if (stop) ns = 2; else if (step_tick) adv = 1'b1;
      2: if (stop) begin ns = 0; np = 0; end
         else if (start) ns = 1;
         else if (step) adv = 1'b1;
      default: ns = 0;
    endcase
    if (adv) begin
      if (!dir) begin np = (m_pos + 1) % RL; nl = (m_pos == RL - 1); end
      else begin np = (m_pos + RL - 1) % RL; nl = (m_pos == 0); end
    end
    m_state = ns; m_pos = np; m_dig = nd; m_lap = nl;
    e.pos = m_pos[3:0]; e.lap = m_lap; e.busy = (m_state != 0); e.seg = m_seg; e.an = m_an;
    sb_q.push_back(e);
  endtask

  // One clock: push the expectation, let the edge happen, compare on the falling edge.
  task automatic tick(input string name);
    exp_t e;
    model_step();
    @(posedge clk);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({name, "_pos"}, pos, e.pos);
      chk({name, "_lap"}, lap, e.lap);
      chk({name, "_busy"}, busy, e.busy);
      chk({name, "_seg"}, seg, e.seg);
      chk({name, "_an"}, an, e.an);
    end
  endtask

  task automatic set_in(input logic st, input logic sp, input logic se, input logic tk,
                        input logic dr, input logic [1:0] tl);
    start = st; stop = sp; step = se; step_tick = tk; dir = dr; tail = tl; scan_tick = 1'b0;
  endtask

  // Scan to digit d, then hold one cycle so the output register shows it.
  task automatic scan_to(input int d);
    step_tick = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0;
    for (int i = 0; i < 8 && m_dig != d; i++) begin
      scan_tick = 1'b1;
      tick("scan");
    end
    scan_tick = 1'b0;
    tick("scan_hold");
  endtask

  function automatic vec_t mk(input logic st, input logic sp, input logic se, input logic tk,
                              input logic dr, input logic [1:0] tl, input int p,
                              input logic l, input logic b);
    vec_t v;
    v.start = st; v.stop = sp; v.step = se; v.tick = tk; v.dir = dr; v.tail = tl;
    v.e_pos = p[3:0]; v.e_lap = l; v.e_busy = b;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 0, 1'b0, 1'b1));
    for (int i = 1; i <= 12; i++) vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, i % 12, i == 12, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 11, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 11, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 11, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 11, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 0, 1'b0, 1'b1));

    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    model_reset();
    #22;
    chk("rst_pos", pos, 4'd0);
    chk("rst_lap", lap, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_an", an, 4'hF);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      set_in(vecs[i].start, vecs[i].stop, vecs[i].step, vecs[i].tick, vecs[i].dir, vecs[i].tail);
      tick("vec");
      chk($sformatf("vec%0d_pos", i), pos, vecs[i].e_pos);
      chk($sformatf("vec%0d_lap", i), lap, vecs[i].e_lap);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
    end

    // Head at 5 (digit 3, segment c), tail 0.
    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
      tick("to5");
    end
    chk("pos5", pos, 4'd5);
    scan_to(3);
    chk("d3_seg", seg, 7'b1111011);
    chk("d3_an", an, 4'b0111);
    scan_to(0);
    chk("d0_seg_off", seg, 7'h7F);
    chk("d0_an", an, 4'b1110);

    // Counter-clockwise through the wrap to 11, tail of two.
    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
      tick("ccw");
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
    tick("ccw_wrap");
    chk("ccw_pos", pos, 4'd11);
    chk("ccw_lap", lap, 1'b1);
    tail = 2'd2;
    scan_to(0);
    chk("tail_d0_seg", seg, 7'b1011110);
    chk("tail_d0_an", an, 4'b1110);
    scan_to(1);
    chk("tail_d1_seg", seg, 7'b1111110);
    chk("tail_d1_an", an, 4'b1101);

    // Run to 7 and pull reset between edges.
    for (int i = 0; i < 8; i++) begin
      set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
      tick("to7");
    end
    chk("pos7", pos, 4'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pos", pos, 4'd0);
    chk("arst_lap", lap, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_seg", seg, 7'h7F);
    chk("arst_an", an, 4'hF);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
      scan_tick = 1'b1;
      tick("post_rst");
      chk("post_rst_pos", pos, 4'd0);
      chk("post_rst_busy", busy, 1'b0);
    end
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    tick("restart");
    chk("restart_busy", busy, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/seg_ring_sequencer.md
Name: seg_ring_sequencer

Overview:
- Sequences the "running circle" animation on an N-digit 7-segment display.
- Consumes the periodic overflow pulse from the prescaler counter as its step tick, and a second faster pulse as its scan tick.
- Walks a lit head, plus an optional tail, around the outer segment ring of all digits.
- Time-multiplexes the digits onto shared segment and anode lines; start/stop/pause/single-step/direction are controlled from board buttons or switches.

Parameters:
- N_DIGITS, 4, number of digits; range 1..8.
- SEG_ACTIVE_LOW, 1, 1 = seg_o bit low lights the segment.
- AN_ACTIVE_LOW, 1, 1 = an_o bit low enables the digit.
- Derived localparams, not overridable:
  - RING_LEN = 2*N_DIGITS+4.
  - POS_W = clog2(RING_LEN).
  - DIG_W = max(1, clog2(N_DIGITS)).

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- step_tick_i  in  1  one-cycle pulse from the prescaler counter; advances the head.
- scan_tick_i  in  1  one-cycle pulse; advances the digit scan.
- start_i  in  1  level-sampled each cycle; start or resume.
- stop_i  in  1  level-sampled each cycle; pause, or clear if already paused.
- step_i  in  1  single-step request, honoured only in PAUSE.
- dir_i  in  1  0 = clockwise (position increments), 1 = counter-clockwise (decrements).
- tail_len_i  in  2  number of lit positions trailing the head (0..3).
- seg_o  out  7  segment lines; bit0=a ... bit6=g.
- an_o  out  N_DIGITS  digit enables; bit0 = leftmost digit.
- pos_o  out  POS_W  current head position.
- lap_o  out  1  one-cycle pulse on ring wrap.
- busy_o  out  1  high in RUN or PAUSE.

Behaviour:
- Ring map, head at p:
  - p in 0..N-1: digit p, segment a.
  - p=N: digit N-1, b. p=N+1: digit N-1, c.
  - p in N+2..2N+1: digit 2N+1-p, segment d.
  - p=2N+2: digit 0, e. p=2N+3: digit 0, f.
  - Segment g is never lit.
- FSM states IDLE, RUN, PAUSE. Reset state is IDLE.
  - IDLE: start_i -> RUN, pos <= 0.
  - RUN: stop_i -> PAUSE. Otherwise, on step_tick_i, pos advances one position per dir_i.
  - PAUSE: stop_i -> IDLE with pos <= 0. Else start_i -> RUN with pos kept. Else step_i -> one advance per dir_i, staying in PAUSE.
  - step_i is a level: each cycle it is high in PAUSE advances one position. The button debouncer/edge-detector is external.
  - start_i and stop_i high in the same cycle: stop wins.
  - step_tick_i coincident with stop_i in RUN: no advance.
- Advance arithmetic, modulo RING_LEN:
  - CW: RING_LEN-1 -> 0 pulses lap_o for one cycle, concurrent with the pos update.
  - CCW: 0 -> RING_LEN-1 pulses lap_o likewise.
  - dir_i change takes effect on the next advance.
- Lit set:
  - Positions head, head-k for k=1..tail_len_i, where "behind" is opposite to dir_i, modulo RING_LEN.
  - Tail positions are computed from the live tail_len_i; no latching.
- Scan:
  - Digit index advances 0..N-1 on each scan_tick_i and wraps to 0. It runs in every state.
  - Registered outputs: seg_o/an_o reflect the digit index and lit set of the previous cycle (1-cycle latency).
  - an_o is one-hot active at the scanned digit in RUN/PAUSE.
  - seg_o is the OR of lit segments mapped to the scanned digit.
  - In IDLE, all an_o are inactive and all seg_o are off.
  - Polarity is applied per the active-low parameters at the output register.
- Reset, asynchronous, any time including mid-run:
  - State IDLE, pos 0, digit index 0.
  - seg_o all off, an_o all inactive (polarity-correct).
  - lap_o 0, busy_o 0.
- busy_o is combinational from state (RUN or PAUSE).

Test Plan (N_DIGITS=4, RING_LEN=12, both polarities active-low):
- Reset then start_i pulse, dir_i=0, tail 0 -> busy_o=1, pos_o=0. After 12 step ticks pos_o returns to 0 and lap_o pulses exactly once, on the 11->0 step.
- Run at pos 5 (digit 3, segment c), tail 0, scan to digit 3 -> an_o=4'b0111, seg_o=7'b1111011. Other digits show seg_o=7'h7F.
- dir_i=1 from pos 0 with one step tick -> pos_o=11 and lap_o pulse. tail_len_i=2 at pos 11 CCW -> lit positions are 11, 0 and 1. Digit 0 shows f+a (seg_o=7'b1011110); digit 1 shows a.
- RUN: stop_i -> PAUSE, and step ticks are ignored. Three step_i cycles -> pos +3. start_i -> RUN with pos kept. stop_i twice -> IDLE, pos 0, an_o=4'hF, busy_o=0.
- start_i and stop_i together in RUN -> PAUSE. Together in IDLE -> stays IDLE. step_tick_i coincident with stop_i -> pos unchanged.
- Assert rst_ni asynchronously mid-RUN at pos 7 -> all outputs take reset values before the next clock edge. After release, no motion until start_i.
